// File: rtl/vga_char_renderer.sv
// rtl/vga_char_renderer.sv - text-mode VGA raster timing and character/font pixel pipeline
//
// Generates 640x480@60 raster timing, advanced one step per pixEn tick, and turns
// character-buffer codes into pixels through an external font ROM.
// Pipeline: stage 0 counters -> stage 1 cell address -> stage 2 font address
// -> stage 3 pins. Colour and syncs share the same 3-tick latency.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   pixEn     pixel tick; every register holds while low
//   charAdd   character-buffer cell index (row*CHARS_HORZ + col), 0 in blanking
//   charData  code at charAdd, synchronous read
//   fontAdd   {charCode, glyphRow}
//   fontData  glyph row bits, MSB = leftmost pixel, synchronous read
//   hSync     active-low horizontal sync
//   vSync     active-low vertical sync
//   red/green/blue  3-bit colour channels
//   vBlank    high while the output raster is in vertical blanking
module vga_char_renderer #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 16,
  parameter int ASCII_SIZE = 8,
  parameter logic [8:0] FG_RGB = 9'o777,
  parameter logic [8:0] BG_RGB = 9'o000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pixEn,
  output logic [11:0]           charAdd,
  input  logic [ASCII_SIZE-1:0] charData,
  output logic [11:0]           fontAdd,
  input  logic [CHAR_W-1:0]     fontData,
  output logic                  hSync,
  output logic                  vSync,
  output logic [2:0]            red,
  output logic [2:0]            green,
  output logic [2:0]            blue,
  output logic                  vBlank
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int CHARS_HORZ = H_VISIBLE / CHAR_W;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CW = $clog2(CHAR_W);
  localparam int CHW = $clog2(CHAR_H);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_C = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_LAST = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_C = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_LAST = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // stage 0
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          act0, hs0, vs0, vb0;
  logic [11:0]   cell0;

  // stage 1
  logic [3:0]    glyph_row1;
  logic [CW-1:0] bit_sel1;
  logic          act1, hs1, vs1, vb1;

  // stage 2
  logic [CW-1:0] bit_sel2;
  logic          act2, hs2, vs2, vb2;

  // stage 3 helpers
  logic [CW-1:0] pix_idx;
  logic          pix;
  logic [8:0]    rgb3;

  always_comb begin
    act0 = 1'b0;
    hs0 = 1'b0;
    vs0 = 1'b0;
    vb0 = 1'b0;
    cell0 = 12'd0;
    act0 = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    hs0 = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    vs0 = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    vb0 = (v_cnt >= V_VIS_C);
    // Blanking addresses cell 0 so the buffer read stays in range.
    if (act0) begin
      cell0 = 12'(v_cnt >> CHW) * 12'(CHARS_HORZ) + 12'(h_cnt >> CW);
    end
  end

  always_comb begin
    pix_idx = '0;
    pix = 1'b0;
    rgb3 = 9'd0;
    // Bit 0 of bit_sel is the leftmost pixel, which lives in the glyph MSB.
    pix_idx = CW'(CHAR_W - 1) - bit_sel2;
    pix = fontData[pix_idx];
    if (act2) begin
      rgb3 = pix ? FG_RGB : BG_RGB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      charAdd <= 12'd0;
      glyph_row1 <= 4'd0;
      bit_sel1 <= '0;
      act1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      vb1 <= 1'b0;
      fontAdd <= 12'd0;
      bit_sel2 <= '0;
      act2 <= 1'b0;
      hs2 <= 1'b0;
      vs2 <= 1'b0;
      vb2 <= 1'b0;
      red <= 3'd0;
      green <= 3'd0;
      blue <= 3'd0;
      hSync <= 1'b1;
      vSync <= 1'b1;
      vBlank <= 1'b0;
    end else if (pixEn) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end

      charAdd <= cell0;
      glyph_row1 <= v_cnt[3:0];
      bit_sel1 <= h_cnt[CW-1:0];
      act1 <= act0;
      hs1 <= hs0;
      vs1 <= vs0;
      vb1 <= vb0;

      // charData now reflects the charAdd registered on the previous tick.
      fontAdd <= 12'({charData, glyph_row1});
      bit_sel2 <= bit_sel1;
      act2 <= act1;
      hs2 <= hs1;
      vs2 <= vs1;
      vb2 <= vb1;

      {red, green, blue} <= rgb3;
      hSync <= ~hs2;
      vSync <= ~vs2;
      vBlank <= vb2;
    end
  end

endmodule

// File: tb/tb_vga_char_renderer.sv
// tb/tb_vga_char_renderer.sv - self-checking bench for vga_char_renderer
module tb_vga_char_renderer;

  logic clk = 1'b0;
  logic rst;
  logic pixEn;

  logic [11:0] ca_b, fa_b, ca_s, fa_s;
  logic [7:0]  cd_b, fd_b, cd_s, fd_s;
  logic        hs_b, vs_b, vb_b, hs_s, vs_s, vb_s;
  logic [2:0]  r_b, g_b, b_b, r_s, g_s, b_s;

  logic [7:0] cmem [0:4095];
  logic [7:0] fmem [0:4095];

  int n;
  int phase;
  int checks;
  int errors;

  int h_prev, h_low, h_fall;
  int v_prev, v_low, v_fall;
  int b_prev, b_high, b_rise;

  typedef struct {
    int phase;
    bit sm;
    int n;
    int fld;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  vga_char_renderer dut_big (
    .clk(clk), .rst(rst), .pixEn(pixEn),
    .charAdd(ca_b), .charData(cd_b), .fontAdd(fa_b), .fontData(fd_b),
    .hSync(hs_b), .vSync(vs_b), .red(r_b), .green(g_b), .blue(b_b), .vBlank(vb_b)
  );

  vga_char_renderer #(
    .H_VISIBLE(64), .H_FRONT(8), .H_SYNC(16), .H_BACK(8),
    .V_VISIBLE(32), .V_FRONT(3), .V_SYNC(2), .V_BACK(4)
  ) dut_small (
    .clk(clk), .rst(rst), .pixEn(pixEn),
    .charAdd(ca_s), .charData(cd_s), .fontAdd(fa_s), .fontData(fd_s),
    .hSync(hs_s), .vSync(vs_s), .red(r_s), .green(g_s), .blue(b_s), .vBlank(vb_s)
  );

  // synchronous-read character buffer and font ROM
  always @(posedge clk) begin
    cd_b <= cmem[ca_b];
    fd_b <= fmem[fa_b];
    cd_s <= cmem[ca_s];
    fd_s <= fmem[fa_s];
  end

  // Expected pins after n ticks since reset release, from raster position arithmetic.
  function automatic logic [35:0] model(input int tk, input bit sm);
    int ht, hv, vt, vv, hs0, hs1, vs0, vs1, cph;
    int p, h, v, a;
    bit act, pix;
    logic [11:0] ca, fa;
    logic [8:0] rgb;
    logic hn, vn, vb;
    logic [7:0] row;
    if (sm) begin
      hv = 64; ht = 96; hs0 = 72; hs1 = 87; vv = 32; vt = 41; vs0 = 35; vs1 = 36; cph = 8;
    end else begin
      hv = 640; ht = 800; hs0 = 656; hs1 = 751; vv = 480; vt = 525; vs0 = 490; vs1 = 491; cph = 80;
    end
    ca = 12'd0; fa = 12'd0; rgb = 9'd0; hn = 1'b1; vn = 1'b1; vb = 1'b0;
    if (tk >= 1) begin
      p = tk - 1; h = p % ht; v = (p / ht) % vt;
      ca = (h < hv && v < vv) ? 12'((v / 16) * cph + h / 8) : 12'd0;
    end
    if (tk == 1) fa = {cmem[0], 4'd0};
    if (tk >= 2) begin
      p = tk - 2; h = p % ht; v = (p / ht) % vt;
      a = (h < hv && v < vv) ? (v / 16) * cph + h / 8 : 0;
      fa = {cmem[a], 4'(v % 16)};
    end
    if (tk >= 3) begin
      p = tk - 3; h = p % ht; v = (p / ht) % vt;
      act = (h < hv && v < vv);
      a = act ? (v / 16) * cph + h / 8 : 0;
      row = fmem[{cmem[a], 4'(v % 16)}];
      pix = row[7 - h % 8];
      rgb = act ? (pix ? 9'o777 : 9'o000) : 9'd0;
      hn = !(h >= hs0 && h <= hs1);
      vn = !(v >= vs0 && v <= vs1);
      vb = (v >= vv);
    end
    return {ca, fa, rgb, hn, vn, vb};
  endfunction

  function automatic logic [35:0] dut_out(input bit sm);
    if (sm) return {ca_s, fa_s, r_s, g_s, b_s, hs_s, vs_s, vb_s};
    return {ca_b, fa_b, r_b, g_b, b_b, hs_b, vs_b, vb_b};
  endfunction

  function automatic logic [11:0] get_fld(input logic [35:0] o, input int fld);
    case (fld)
      0: return o[35:24];
      1: return o[23:12];
      2: return {3'd0, o[11:3]};
      3: return {11'd0, o[2]};
      default: return {11'd0, o[1]};
    endcase
  endfunction

  task automatic chk_vec(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got=%h want=%h (charAdd,fontAdd,rgb,hs,vs,vb)", name, n, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s n=%0d got=%0d want=%0d", name, n, act, exp);
    end
  endtask

  task automatic check_all();
    chk_vec("big_pins", dut_out(1'b0), model(n, 1'b0));
    chk_vec("small_pins", dut_out(1'b1), model(n, 1'b1));
  endtask

  task automatic reset_meas();
    h_prev = 1; h_low = 0; h_fall = -1;
    v_prev = 1; v_low = 0; v_fall = -1;
    b_prev = 0; b_high = 0; b_rise = -1;
  endtask

  task automatic measure();
    if (hs_b == 1'b0) h_low++;
    if (h_prev == 1 && hs_b == 1'b0) begin
      if (h_fall < 0) chk_int("hsync_first_fall", n, 659);
      else chk_int("hsync_period", n - h_fall, 800);
      h_fall = n;
    end
    if (h_prev == 0 && hs_b == 1'b1) begin
      chk_int("hsync_width", h_low, 96);
      h_low = 0;
    end
    h_prev = int'(hs_b);

    if (vs_s == 1'b0) v_low++;
    if (v_prev == 1 && vs_s == 1'b0) begin
      if (v_fall < 0) chk_int("vsync_first_fall", n, 3363);
      else chk_int("vsync_period", n - v_fall, 3936);
      v_fall = n;
    end
    if (v_prev == 0 && vs_s == 1'b1) begin
      chk_int("vsync_width", v_low, 192);
      v_low = 0;
    end
    v_prev = int'(vs_s);

    if (vb_s == 1'b1) b_high++;
    if (b_prev == 0 && vb_s == 1'b1) begin
      if (b_rise < 0) chk_int("vblank_first_rise", n, 3075);
      else chk_int("vblank_period", n - b_rise, 3936);
      b_rise = n;
    end
    if (b_prev == 1 && vb_s == 1'b0) begin
      chk_int("vblank_width", b_high, 864);
      b_high = 0;
    end
    b_prev = int'(vb_s);
  endtask

  task automatic tick(input int gap);
    @(negedge clk) pixEn = 1'b1;
    @(negedge clk) pixEn = 1'b0;
    if (!rst) n++;
    check_all();
    if (!rst) begin
      measure();
      for (int i = 0; i < vecs.size(); i++) begin
        if (vecs[i].phase == phase && vecs[i].n == n) begin
          chk_int($sformatf("vec%0d", i), int'(get_fld(dut_out(vecs[i].sm), vecs[i].fld)),
                  int'(vecs[i].exp));
        end
      end
    end
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    // phase 1: constant glyph 8'h81 for code 8'h41
    vecs.push_back('{1, 1'b0, 1, 0, 12'd0});
    vecs.push_back('{1, 1'b0, 9, 0, 12'd1});
    vecs.push_back('{1, 1'b0, 2, 1, 12'h410});
    vecs.push_back('{1, 1'b0, 812, 1, 12'h411});
    vecs.push_back('{1, 1'b0, 2, 2, 12'o000});
    vecs.push_back('{1, 1'b0, 3, 2, 12'o777});
    vecs.push_back('{1, 1'b0, 4, 2, 12'o000});
    vecs.push_back('{1, 1'b0, 9, 2, 12'o000});
    vecs.push_back('{1, 1'b0, 10, 2, 12'o777});
    vecs.push_back('{1, 1'b0, 11, 2, 12'o777});
    vecs.push_back('{1, 1'b0, 12, 2, 12'o000});
    vecs.push_back('{1, 1'b0, 642, 2, 12'o777});
    vecs.push_back('{1, 1'b0, 643, 2, 12'o000});
    vecs.push_back('{1, 1'b0, 658, 3, 12'd1});
    vecs.push_back('{1, 1'b0, 659, 3, 12'd0});
    vecs.push_back('{1, 1'b0, 754, 3, 12'd0});
    vecs.push_back('{1, 1'b0, 755, 3, 12'd1});
    // phase 2: address walk on line 17 and last visible cell
    vecs.push_back('{2, 1'b0, 13601, 0, 12'd80});
    vecs.push_back('{2, 1'b0, 13608, 0, 12'd80});
    vecs.push_back('{2, 1'b0, 13609, 0, 12'd81});
    vecs.push_back('{2, 1'b0, 14240, 0, 12'd159});
    vecs.push_back('{2, 1'b0, 14241, 0, 12'd0});
    vecs.push_back('{2, 1'b0, 14400, 0, 12'd0});
    vecs.push_back('{2, 1'b1, 3040, 0, 12'd15});
    vecs.push_back('{2, 1'b1, 3041, 0, 12'd0});
    // phase 3: vSync after mid-frame reset
    vecs.push_back('{3, 1'b1, 3362, 4, 12'd1});
    vecs.push_back('{3, 1'b1, 3363, 4, 12'd0});

    checks = 0;
    errors = 0;
    n = 0;
    phase = 0;
    rst = 1'b1;
    pixEn = 1'b0;
    reset_meas();
    for (int i = 0; i < 4096; i++) begin
      cmem[i] = 8'h41;
      fmem[i] = 8'h81;
    end

    repeat (3) @(negedge clk);
    repeat (10) tick(1);
    @(negedge clk) rst = 1'b0;
    reset_meas();
    phase = 1;
    while (n < 1700) tick(1 + int'($urandom_range(0, 1)));

    // asynchronous reset mid-line, between clock edges
    #2 rst = 1'b1;
    n = 0;
    #1 check_all();
    for (int i = 0; i < 4096; i++) begin
      cmem[i] = 8'($urandom);
      fmem[i] = 8'($urandom);
    end
    repeat (5) tick(1);
    @(negedge clk) rst = 1'b0;
    reset_meas();
    phase = 2;
    while (n < 17694) begin
      if (n == 5000) begin
        tick(1);
        // stall mid-line: every pin must stay at the tick-5001 values
        repeat (50) begin
          @(negedge clk);
          check_all();
        end
      end else begin
        tick(1 + int'($urandom_range(0, 1)));
      end
    end

    // small raster is now at vCnt=20, hCnt=30
    #2 rst = 1'b1;
    n = 0;
    #1 check_all();
    repeat (3) tick(1);
    @(negedge clk) rst = 1'b0;
    reset_meas();
    phase = 3;
    while (n < 3400) tick(1 + int'($urandom_range(0, 1)));
    chk_int("vsync_after_reset", v_fall, 3363);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
